// File: rtl/wormhole_switch_rr.sv
// Wormhole crossbar: per-output round-robin head arbitration, path locked from
// head to tail, and an optional 2-entry skid FIFO on every output.
module wormhole_switch_rr #(
  parameter int INPUTS     = 4,
  parameter int OUTPUTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = $clog2(OUTPUTS),
  parameter int OUT_REG    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INPUTS*DATA_WIDTH-1:0]   data_in,
  input  logic [INPUTS*DEST_WIDTH-1:0]   dest_in,
  input  logic [INPUTS-1:0]              head_in,
  input  logic [INPUTS-1:0]              tail_in,
  input  logic [INPUTS-1:0]              valid_in,
  output logic [INPUTS-1:0]              ready_in,
  output logic [OUTPUTS*DATA_WIDTH-1:0]  data_out,
  output logic [OUTPUTS-1:0]             tail_out,
  output logic [OUTPUTS-1:0]             valid_out,
  input  logic [OUTPUTS-1:0]             ready_out,
  output logic [OUTPUTS-1:0]             output_busy,
  output logic [INPUTS-1:0]              proto_err
);

  localparam int IW = $clog2(INPUTS);
  localparam logic [DEST_WIDTH:0] DEST_LIMIT = (DEST_WIDTH+1)'(OUTPUTS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_r     [OUTPUTS];
  state_t                  state_nxt_s [OUTPUTS];
  logic [IW-1:0]           owner_r     [OUTPUTS];
  logic [IW-1:0]           owner_nxt_s [OUTPUTS];
  logic [IW-1:0]           ptr_r       [OUTPUTS];
  logic [IW-1:0]           ptr_nxt_s   [OUTPUTS];

  logic [DEST_WIDTH-1:0]   dest_s      [INPUTS];
  logic [INPUTS-1:0]       dest_ok_s;
  logic [INPUTS-1:0]       in_locked_s;
  logic [INPUTS-1:0]       cand_s      [OUTPUTS];
  logic [INPUTS-1:0]       grant_s     [OUTPUTS];
  logic [IW-1:0]           sel_s       [OUTPUTS];
  logic [OUTPUTS-1:0]      sel_valid_s;
  logic [OUTPUTS-1:0]      sel_tail_s;
  logic [DATA_WIDTH-1:0]   sel_data_s  [OUTPUTS];
  logic [OUTPUTS-1:0]      stage_ready_s;
  logic [OUTPUTS-1:0]      hs_s;
  logic [INPUTS-1:0]       ready_s;
  logic [INPUTS-1:0]       proto_err_r;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
    next_idx = (cur == IW'(INPUTS-1)) ? {IW{1'b0}} : cur + IW'(1);
  endfunction

  // Destination slicing and range check per input.
  always_comb begin
    for (int i = 0; i < INPUTS; i++) begin
      dest_s[i]    = dest_in[i*DEST_WIDTH +: DEST_WIDTH];
      dest_ok_s[i] = ({1'b0, dest_s[i]} < DEST_LIMIT);
    end
  end

  // An input owning any output lock routes by that lock, not by dest_in.
  always_comb begin
    in_locked_s = {INPUTS{1'b0}};
    for (int o = 0; o < OUTPUTS; o++) begin
      for (int i = 0; i < INPUTS; i++) begin
        in_locked_s[i] = in_locked_s[i] |
                         ((state_r[o] == LOCKED) && (owner_r[o] == IW'(i)));
      end
    end
  end

  // Per-output selection: the lock owner when LOCKED, else the round-robin winner.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    for (int o = 0; o < OUTPUTS; o++) begin
      grant_s[o]     = {INPUTS{1'b0}};
      sel_s[o]       = {IW{1'b0}};
      sel_valid_s[o] = 1'b0;
      found          = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
        cand_s[o][i] = valid_in[i] & head_in[i] & ~in_locked_s[i] & dest_ok_s[i] &
                       (dest_s[i] == DEST_WIDTH'(o));
      end
      if (state_r[o] == LOCKED) begin
        sel_s[o]       = owner_r[o];
        sel_valid_s[o] = valid_in[owner_r[o]];
      end else begin
        // Scan backwards from the pointer so the nearest candidate at/after ptr wins.
        for (int j = INPUTS - 1; j >= 0; j--) begin
          idx      = (int'(ptr_r[o]) + j) % INPUTS;
          sel_s[o] = cand_s[o][idx] ? IW'(idx) : sel_s[o];
          found    = found | cand_s[o][idx];
        end
        sel_valid_s[o] = found;
      end
      grant_s[o][sel_s[o]] = (state_r[o] == LOCKED) | found;
      sel_data_s[o]        = data_in[sel_s[o]*DATA_WIDTH +: DATA_WIDTH];
      sel_tail_s[o]        = tail_in[sel_s[o]];
      hs_s[o]              = sel_valid_s[o] & stage_ready_s[o];
    end
  end

  // Input ready: the granting output's stage readiness, forced low during reset.
  always_comb begin
    ready_s = {INPUTS{1'b0}};
    for (int o = 0; o < OUTPUTS; o++) begin
      ready_s = ready_s | (grant_s[o] & {INPUTS{stage_ready_s[o]}});
    end
    ready_in = rst ? ready_s : {INPUTS{1'b0}};
  end

  // Per-output lock FSM next state and round-robin pointer update.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      state_nxt_s[o] = state_r[o];
      owner_nxt_s[o] = owner_r[o];
      ptr_nxt_s[o]   = ptr_r[o];
      case (state_r[o])
        IDLE: begin
          if (hs_s[o]) begin
            ptr_nxt_s[o] = next_idx(sel_s[o]);
            if (!sel_tail_s[o]) begin
              state_nxt_s[o] = LOCKED;
              owner_nxt_s[o] = sel_s[o];
            end else begin
              state_nxt_s[o] = IDLE;
            end
          end else begin
            state_nxt_s[o] = IDLE;
          end
        end
        LOCKED: begin
          if (hs_s[o] && sel_tail_s[o]) begin
            state_nxt_s[o] = IDLE;
          end else begin
            state_nxt_s[o] = LOCKED;
          end
        end
        default: begin
          state_nxt_s[o] = IDLE;
        end
      endcase
    end
  end

  // Lock state, owner, pointer and sticky protocol-error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_r[o] <= IDLE;
        owner_r[o] <= {IW{1'b0}};
        ptr_r[o]   <= {IW{1'b0}};
      end
      proto_err_r <= {INPUTS{1'b0}};
    end else begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_r[o] <= state_nxt_s[o];
        owner_r[o] <= owner_nxt_s[o];
        ptr_r[o]   <= ptr_nxt_s[o];
      end
      proto_err_r <= proto_err_r |
                     (valid_in & ~in_locked_s & (~head_in | ~dest_ok_s));
    end
  end

  // Lock status and error flags straight from registers.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      output_busy[o] = (state_r[o] == LOCKED);
    end
    proto_err = proto_err_r;
  end

  if (OUT_REG != 0) begin : g_skid
    logic [DATA_WIDTH:0] mem_r [OUTPUTS][2];
    logic [1:0]          cnt_r [OUTPUTS];
    logic [OUTPUTS-1:0]  wr_r;
    logic [OUTPUTS-1:0]  rd_r;
    logic [OUTPUTS-1:0]  pop_s;

    // Stage is ready while the FIFO has a free slot; pop on downstream handshake.
    always_comb begin
      for (int o = 0; o < OUTPUTS; o++) begin
        stage_ready_s[o] = (cnt_r[o] != 2'd2);
        pop_s[o]         = (cnt_r[o] != 2'd0) & ready_out[o];
      end
    end

    // Skid FIFO storage and occupancy.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int o = 0; o < OUTPUTS; o++) begin
          mem_r[o][0] <= {(DATA_WIDTH+1){1'b0}};
          mem_r[o][1] <= {(DATA_WIDTH+1){1'b0}};
          cnt_r[o]    <= 2'd0;
        end
        wr_r <= {OUTPUTS{1'b0}};
        rd_r <= {OUTPUTS{1'b0}};
      end else begin
        for (int o = 0; o < OUTPUTS; o++) begin
          if (hs_s[o]) begin
            mem_r[o][wr_r[o]] <= {sel_tail_s[o], sel_data_s[o]};
            wr_r[o]           <= ~wr_r[o];
          end
          if (pop_s[o]) begin
            rd_r[o] <= ~rd_r[o];
          end
          case ({hs_s[o], pop_s[o]})
            2'b10:   cnt_r[o] <= cnt_r[o] + 2'd1;
            2'b01:   cnt_r[o] <= cnt_r[o] - 2'd1;
            default: cnt_r[o] <= cnt_r[o];
          endcase
        end
      end
    end

    // FIFO head drives the output link; zero when empty.
    always_comb begin
      for (int o = 0; o < OUTPUTS; o++) begin
        valid_out[o] = (cnt_r[o] != 2'd0);
        {tail_out[o], data_out[o*DATA_WIDTH +: DATA_WIDTH]} =
          (cnt_r[o] != 2'd0) ? mem_r[o][rd_r[o]] : {(DATA_WIDTH+1){1'b0}};
      end
    end
  end else begin : g_comb
    // Combinational crossbar: selected flit goes straight to the link.
    always_comb begin
      for (int o = 0; o < OUTPUTS; o++) begin
        stage_ready_s[o] = ready_out[o];
        valid_out[o]     = sel_valid_s[o] & rst;
        {tail_out[o], data_out[o*DATA_WIDTH +: DATA_WIDTH]} =
          (sel_valid_s[o] & rst) ? {sel_tail_s[o], sel_data_s[o]} : {(DATA_WIDTH+1){1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_wormhole_switch_rr.sv
// Directed self-checking bench for wormhole_switch_rr (4x4, 8-bit, OUT_REG=1).
module tb_wormhole_switch_rr;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [7:0]  dest_in;
  logic [3:0]  head_in, tail_in, valid_in, ready_in;
  logic [31:0] data_out;
  logic [3:0]  tail_out, valid_out, ready_out, output_busy, proto_err;

  int checks = 0;
  int errors = 0;

  wormhole_switch_rr #(
    .INPUTS(4), .OUTPUTS(4), .DATA_WIDTH(8), .DEST_WIDTH(2), .OUT_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .dest_in(dest_in), .head_in(head_in), .tail_in(tail_in),
    .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .tail_out(tail_out), .valid_out(valid_out),
    .ready_out(ready_out), .output_busy(output_busy), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic h, input logic t,
                       input logic [1:0] d, input logic [7:0] dat);
    valid_in[i]         = v;
    head_in[i]          = h;
    tail_in[i]          = t;
    dest_in[i*2 +: 2]   = d;
    data_in[i*8 +: 8]   = dat;
  endtask

  initial begin
    int         idx;
    int         pop_idx;
    logic       hs;
    logic [3:0] e;

    rst = 1'b0;
    data_in = 32'h0; dest_in = 8'h0; head_in = 4'h0; tail_in = 4'h0; valid_in = 4'h0;
    ready_out = 4'hF;

    // Reset state, including a head presented while reset is held
    drive(0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h99);
    #2;
    chk("rst_valid_out", valid_out, 4'h0);
    chk("rst_ready_in", ready_in, 4'h0);
    chk("rst_busy", output_busy, 4'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_tail_out", tail_out, 4'h0);
    chk("rst_proto_err", proto_err, 4'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    step();

    // Single-flit packet: input 2 -> output 3
    drive(2, 1'b1, 1'b1, 1'b1, 2'd3, 8'hA5);
    #1;
    chk("sf_ready_in", ready_in, 4'b0100);
    step();
    drive(2, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("sf_valid_out", valid_out, 4'b1000);
    chk("sf_data", data_out[31:24], 8'hA5);
    chk("sf_tail", tail_out, 4'b1000);
    chk("sf_busy", output_busy, 4'h0);
    step();
    chk("sf_drain", valid_out, 4'h0);

    // Wormhole lock: input 0 owns output 1, input 3's head waits
    drive(0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h10);
    #1;
    chk("wh_head_rdy", ready_in, 4'b0001);
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h11);
    drive(3, 1'b1, 1'b1, 1'b1, 2'd1, 8'h30);
    #1;
    chk("wh_rdy1", ready_in, 4'b0001);
    chk("wh_busy", output_busy, 4'b0010);
    chk("wh_out10", data_out[15:8], 8'h10);
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h12);
    #1;
    chk("wh_rdy2", ready_in, 4'b0001);
    chk("wh_out11", data_out[15:8], 8'h11);
    step();
    drive(0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h13);
    #1;
    chk("wh_rdy3", ready_in, 4'b0001);
    chk("wh_out12", data_out[15:8], 8'h12);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("wh_in3_grant", ready_in, 4'b1000);
    chk("wh_out13", data_out[15:8], 8'h13);
    chk("wh_tail13", tail_out, 4'b0010);
    chk("wh_unlock", output_busy, 4'h0);
    step();
    drive(3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("wh_out30", data_out[15:8], 8'h30);
    chk("wh_valid30", valid_out, 4'b0010);
    step();
    chk("wh_drain", valid_out, 4'h0);

    // Round-robin: all inputs send single-flit packets to output 0
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 1'b1, 2'd0, 8'hC0 + 8'(i));
    for (int k = 0; k < 8; k++) begin
      #1;
      e = 4'b0001 << (k % 4);
      chk("rr_grant", ready_in, e);
      if (k > 0) begin
        chk("rr_data", data_out[7:0], 8'hC0 + 8'((k - 1) % 4));
        chk("rr_valid", valid_out, 4'b0001);
      end
      step();
    end
    valid_in = 4'h0;
    #1;
    chk("rr_last", data_out[7:0], 8'hC3);
    step();
    chk("rr_drain", valid_out, 4'h0);

    // Backpressure: 6-flit packet from input 1 to output 2, ready_out[2] low cycles 2..6
    idx = 0;
    pop_idx = 0;
    for (int k = 0; k < 14; k++) begin
      if (idx < 6) drive(1, 1'b1, idx == 0, idx == 5, 2'd2, 8'h20 + 8'(idx));
      else         drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      ready_out = (k >= 2 && k <= 6) ? 4'b1011 : 4'b1111;
      #1;
      hs = valid_in[1] & ready_in[1];
      chk("bp_ready", 32'(ready_in[1]), 32'((idx < 6) && !(k >= 3 && k <= 7)));
      if (k == 3) chk("bp_full_valid", data_out[23:16], 8'h21);
      if (valid_out[2] && ready_out[2]) begin
        chk("bp_data", data_out[23:16], 8'h20 + 8'(pop_idx));
        chk("bp_tail", 32'(tail_out[2]), 32'(pop_idx == 5));
        pop_idx++;
      end
      step();
      if (hs) idx++;
    end
    chk("bp_count", pop_idx, 6);
    chk("bp_busy_end", output_busy, 4'h0);
    ready_out = 4'hF;

    // Protocol error: unlocked body flit on input 1; input 0 unaffected
    drive(1, 1'b1, 1'b0, 1'b0, 2'd2, 8'h55);
    drive(0, 1'b1, 1'b1, 1'b1, 2'd3, 8'h66);
    #1;
    chk("pe_ready", ready_in, 4'b0001);
    chk("pe_not_yet", proto_err, 4'h0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("pe_set", proto_err, 4'b0010);
    chk("pe_other_data", data_out[31:24], 8'h66);
    drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    step();
    chk("pe_sticky", proto_err, 4'b0010);

    // Async reset mid-packet
    drive(2, 1'b1, 1'b1, 1'b0, 2'd0, 8'h70);
    step();
    drive(2, 1'b1, 1'b0, 1'b0, 2'd0, 8'h71);
    #1;
    chk("ar_busy_pre", output_busy, 4'b0001);
    chk("ar_rdy_pre", ready_in, 4'b0100);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", output_busy, 4'h0);
    chk("ar_valid", valid_out, 4'h0);
    chk("ar_ready", ready_in, 4'h0);
    chk("ar_perr", proto_err, 4'h0);
    drive(2, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1 rst = 1'b1;
    step();
    drive(1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h81);
    drive(3, 1'b1, 1'b1, 1'b1, 2'd0, 8'h83);
    #1;
    chk("ar_ptr0_grant", ready_in, 4'b0010);
    step();
    drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("ar_fresh_data", data_out[7:0], 8'h81);
    chk("ar_fresh_busy", output_busy, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
